// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one request at a time to a
// stalling instruction memory, holds the returned word until decode takes it.
//
// state  | meaning
// FETCH  | idle; issue request at pc unless halt/redirect this cycle
// WAIT   | request outstanding, response will be accepted
// FLUSH  | request outstanding, response will be discarded (redirected)
// HOLD   | fetched instruction presented to decode, waiting for consumption
// HALTED | decode retired HALT; terminal until rst
// ERR    | memory error or response timeout; terminal until rst
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP      = 16'h0800,
  parameter int unsigned TIMEOUT  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        stall_in,
  input  logic        mem_done,
  input  logic        mem_err,
  input  logic [15:0] mem_data,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  output logic [15:0] instr,
  output logic        valid,
  output logic [15:0] pc_out,
  output logic [15:0] pc2,
  output logic        err,
  output logic        halted
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    WAIT   = 3'd1,
    FLUSH  = 3'd2,
    HOLD   = 3'd3,
    HALTED = 3'd4,
    ERR    = 3'd5
  } state_t;

  // Down-counter loaded on request; zero is the last cycle allowed without a response.
  localparam logic [7:0] TO_LOAD = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [15:0] pc_inc;
  logic [7:0]  cnt, cnt_nxt, cnt_dec;
  logic        tmo;
  logic [15:0] instr_nxt, pc_out_nxt, pc2_nxt;
  logic        valid_nxt, err_nxt, halted_nxt;

  assign pc_inc   = pc + 16'd2;
  assign tmo      = (cnt == 8'd0);
  assign cnt_dec  = tmo ? cnt : cnt - 8'd1;
  assign mem_en   = (state == FETCH) & ~halt & ~redirect;
  assign mem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      cnt    <= TO_LOAD;
      instr  <= NOP;
      valid  <= 1'b0;
      pc_out <= RESET_PC;
      pc2    <= RESET_PC + 16'd2;
      err    <= 1'b0;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      cnt    <= cnt_nxt;
      instr  <= instr_nxt;
      valid  <= valid_nxt;
      pc_out <= pc_out_nxt;
      pc2    <= pc2_nxt;
      err    <= err_nxt;
      halted <= halted_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    cnt_nxt    = cnt;
    instr_nxt  = instr;
    valid_nxt  = valid;
    pc_out_nxt = pc_out;
    pc2_nxt    = pc2;
    err_nxt    = err;
    halted_nxt = halted;

    unique case (state)
      FETCH: begin
        if (halt) begin
          state_nxt  = HALTED;
          halted_nxt = 1'b1;
        end else if (redirect) begin
          pc_nxt = redirect_pc;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = TO_LOAD;
        end
      end

      WAIT: begin
        if (redirect) begin
          pc_nxt = redirect_pc;
          if (mem_done) begin
            state_nxt = FETCH;
          end else begin
            state_nxt = FLUSH;
            cnt_nxt   = cnt_dec;
          end
        end else if (mem_done && mem_err) begin
          state_nxt = ERR;
          err_nxt   = 1'b1;
        end else if (mem_done) begin
          state_nxt  = HOLD;
          instr_nxt  = mem_data;
          valid_nxt  = 1'b1;
          pc_out_nxt = pc;
          pc2_nxt    = pc_inc;
          pc_nxt     = pc_inc;
        end else if (tmo) begin
          state_nxt = ERR;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_dec;
        end
      end

      FLUSH: begin
        if (redirect) pc_nxt = redirect_pc;
        if (mem_done) begin
          state_nxt = FETCH;
        end else if (tmo) begin
          state_nxt = ERR;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_dec;
        end
      end

      HOLD: begin
        if (redirect) begin
          state_nxt = FETCH;
          valid_nxt = 1'b0;
          instr_nxt = NOP;
          pc_nxt    = redirect_pc;
        end else if (!stall_in) begin
          state_nxt = FETCH;
          valid_nxt = 1'b0;
          instr_nxt = NOP;
        end
      end

      HALTED, ERR: begin
        valid_nxt = 1'b0;
        instr_nxt = NOP;
      end

      default: begin
        state_nxt = FETCH;
        valid_nxt = 1'b0;
        instr_nxt = NOP;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: per-cycle vector table for the main fetch flow plus
// hand-written halt/timeout/error/wrap sequences; fetched words scoreboarded.
module tb_fetch_ctrl;

  localparam logic [15:0] NOP = 16'h0800;
  localparam logic [15:0] Z   = 16'h0000;
  localparam logic        O   = 1'b0;
  localparam logic        I   = 1'b1;

  logic        clk = 1'b0;
  logic        rst, halt, redirect, stall_in, mem_done, mem_err;
  logic [15:0] redirect_pc, mem_data;
  logic        mem_en, valid, err, halted;
  logic [15:0] mem_addr, instr, pc_out, pc2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(16'h0000), .NOP(NOP), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .halt(halt), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall_in(stall_in), .mem_done(mem_done),
    .mem_err(mem_err), .mem_data(mem_data), .mem_en(mem_en),
    .mem_addr(mem_addr), .instr(instr), .valid(valid), .pc_out(pc_out),
    .pc2(pc2), .err(err), .halted(halted)
  );

  typedef struct {
    logic        rst, halt, redir;
    logic [15:0] rpc;
    logic        stall, done, merr;
    logic [15:0] data;
    logic        acc, chk;
    logic        en;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] ins, pco, p2;
  } vec_t;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] pc;
  } exp_t;

  vec_t tbl[24];
  exp_t sbq[$];

  function automatic vec_t v(input logic r, h, rd, input logic [15:0] rp,
                             input logic st, d, me, input logic [15:0] dt,
                             input logic ac, ck, en, input logic [15:0] ad,
                             input logic vl, input logic [15:0] in_, po, p2);
    vec_t x;
    x.rst = r; x.halt = h; x.redir = rd; x.rpc = rp;
    x.stall = st; x.done = d; x.merr = me; x.data = dt;
    x.acc = ac; x.chk = ck; x.en = en; x.addr = ad;
    x.vld = vl; x.ins = in_; x.pco = po; x.p2 = p2;
    return x;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, h, rd, input logic [15:0] rp,
                       input logic st, d, me, input logic [15:0] dt);
    @(negedge clk);
    rst = r; halt = h; redirect = rd; redirect_pc = rp;
    stall_in = st; mem_done = d; mem_err = me; mem_data = dt;
    #1;
  endtask

  // Scoreboard: every newly presented instruction must match the oldest accepted response.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (valid === 1'b1 && !prev_v) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got instr %h pc_out %h, required none", instr, pc_out);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk16("sb_instr", instr, e.ins);
        chk16("sb_pc_out", pc_out, e.pc);
        chk16("sb_pc2", pc2, e.pc + 16'd2);
      end
    end
    prev_v = (valid === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = Z;
    stall_in = 1'b0; mem_done = 1'b0; mem_err = 1'b0; mem_data = Z;

    //          rst halt rd rpc        st d  me data       acc chk en addr      vld ins       pco       pc2
    tbl[0]  = v(I, O, O, Z,          O, O, O, Z,          O, O, O, Z,         O, Z,        Z,        Z);
    tbl[1]  = v(O, O, O, Z,          O, O, O, Z,          O, I, I, 16'h0000,  O, NOP,      16'h0000, 16'h0002);
    tbl[2]  = v(O, O, O, Z,          O, I, O, 16'h1111,   I, I, O, 16'h0000,  O, NOP,      16'h0000, 16'h0002);
    tbl[3]  = v(O, O, O, Z,          O, O, O, Z,          O, I, O, 16'h0002,  I, 16'h1111, 16'h0000, 16'h0002);
    tbl[4]  = v(O, O, O, Z,          O, O, O, Z,          O, I, I, 16'h0002,  O, NOP,      16'h0000, 16'h0002);
    tbl[5]  = v(O, O, O, Z,          O, I, O, 16'h2222,   I, I, O, 16'h0002,  O, NOP,      16'h0000, 16'h0002);
    tbl[6]  = v(O, O, O, Z,          O, O, O, Z,          O, I, O, 16'h0004,  I, 16'h2222, 16'h0002, 16'h0004);
    tbl[7]  = v(O, O, O, Z,          O, O, O, Z,          O, I, I, 16'h0004,  O, NOP,      16'h0002, 16'h0004);
    tbl[8]  = v(O, O, O, Z,          O, I, O, 16'h3333,   I, I, O, 16'h0004,  O, NOP,      16'h0002, 16'h0004);
    tbl[9]  = v(O, O, O, Z,          I, O, O, Z,          O, I, O, 16'h0006,  I, 16'h3333, 16'h0004, 16'h0006);
    tbl[10] = v(O, O, O, Z,          I, O, O, Z,          O, I, O, 16'h0006,  I, 16'h3333, 16'h0004, 16'h0006);
    tbl[11] = v(O, O, O, Z,          I, O, O, Z,          O, I, O, 16'h0006,  I, 16'h3333, 16'h0004, 16'h0006);
    tbl[12] = v(O, O, O, Z,          I, O, O, Z,          O, I, O, 16'h0006,  I, 16'h3333, 16'h0004, 16'h0006);
    tbl[13] = v(O, O, O, Z,          O, O, O, Z,          O, I, O, 16'h0006,  I, 16'h3333, 16'h0004, 16'h0006);
    tbl[14] = v(O, O, O, Z,          O, O, O, Z,          O, I, I, 16'h0006,  O, NOP,      16'h0004, 16'h0006);
    tbl[15] = v(O, O, I, 16'h0040,   O, O, O, Z,          O, I, O, 16'h0006,  O, NOP,      16'h0004, 16'h0006);
    tbl[16] = v(O, O, O, Z,          O, O, O, Z,          O, I, O, 16'h0040,  O, NOP,      16'h0004, 16'h0006);
    tbl[17] = v(O, O, O, Z,          O, I, O, 16'hDEAD,   O, I, O, 16'h0040,  O, NOP,      16'h0004, 16'h0006);
    tbl[18] = v(O, O, O, Z,          O, O, O, Z,          O, I, I, 16'h0040,  O, NOP,      16'h0004, 16'h0006);
    tbl[19] = v(O, O, O, Z,          O, I, O, 16'h4444,   I, I, O, 16'h0040,  O, NOP,      16'h0004, 16'h0006);
    tbl[20] = v(O, O, I, 16'h0100,   I, O, O, Z,          O, I, O, 16'h0042,  I, 16'h4444, 16'h0040, 16'h0042);
    tbl[21] = v(O, O, O, Z,          I, O, O, Z,          O, I, I, 16'h0100,  O, NOP,      16'h0040, 16'h0042);
    tbl[22] = v(O, O, O, Z,          O, I, O, 16'h5555,   I, I, O, 16'h0100,  O, NOP,      16'h0040, 16'h0042);
    tbl[23] = v(O, O, O, Z,          O, O, O, Z,          O, I, O, 16'h0102,  I, 16'h5555, 16'h0100, 16'h0102);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].rst, tbl[i].halt, tbl[i].redir, tbl[i].rpc,
            tbl[i].stall, tbl[i].done, tbl[i].merr, tbl[i].data);
      if (tbl[i].acc) sbq.push_back('{tbl[i].data, tbl[i].addr});
      if (tbl[i].chk) begin
        chk1($sformatf("r%0d mem_en", i), mem_en, tbl[i].en);
        chk16($sformatf("r%0d mem_addr", i), mem_addr, tbl[i].addr);
        chk1($sformatf("r%0d valid", i), valid, tbl[i].vld);
        chk16($sformatf("r%0d instr", i), instr, tbl[i].ins);
        chk16($sformatf("r%0d pc_out", i), pc_out, tbl[i].pco);
        chk16($sformatf("r%0d pc2", i), pc2, tbl[i].p2);
        chk1($sformatf("r%0d err", i), err, 1'b0);
        chk1($sformatf("r%0d halted", i), halted, 1'b0);
      end
    end

    // Halt wins over a same-cycle redirect; HALTED is sticky and ignores mem_done.
    drive(O, I, I, 16'h0200, O, O, O, Z);
    chk1("halt_mem_en", mem_en, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(O, O, O, Z, O, (k == 1), O, 16'h9999);
      chk1($sformatf("halted_%0d", k), halted, 1'b1);
      chk1($sformatf("halted_mem_en_%0d", k), mem_en, 1'b0);
      chk1($sformatf("halted_valid_%0d", k), valid, 1'b0);
      chk16($sformatf("halted_instr_%0d", k), instr, NOP);
      chk16($sformatf("halted_pc_%0d", k), mem_addr, 16'h0102);
    end
    drive(I, O, O, Z, O, O, O, Z);
    drive(O, O, O, Z, O, O, O, Z);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b1);
    chk16("rst_mem_addr", mem_addr, 16'h0000);

    // Response withheld: four WAIT cycles, then sticky err.
    for (int k = 0; k < 4; k++) begin
      drive(O, O, O, Z, O, O, O, Z);
      chk1($sformatf("wait_err_%0d", k), err, 1'b0);
      chk1($sformatf("wait_mem_en_%0d", k), mem_en, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      drive(O, O, O, Z, O, (k == 0), O, 16'hAAAA);
      chk1($sformatf("tmo_err_%0d", k), err, 1'b1);
      chk1($sformatf("tmo_mem_en_%0d", k), mem_en, 1'b0);
      chk1($sformatf("tmo_valid_%0d", k), valid, 1'b0);
    end

    // Memory error response: no instruction presented, err sticky.
    drive(I, O, O, Z, O, O, O, Z);
    drive(O, O, O, Z, O, O, O, Z);
    chk1("merr_req", mem_en, 1'b1);
    chk1("merr_err_clr", err, 1'b0);
    drive(O, O, O, Z, O, I, I, 16'hBEEF);
    chk1("merr_valid0", valid, 1'b0);
    drive(O, O, O, Z, O, O, O, Z);
    chk1("merr_err", err, 1'b1);
    chk1("merr_valid1", valid, 1'b0);
    chk16("merr_instr", instr, NOP);
    drive(O, O, O, Z, O, O, O, Z);
    chk1("merr_err_sticky", err, 1'b1);
    chk1("merr_mem_en", mem_en, 1'b0);

    // PC wrap at 16'hFFFE.
    drive(I, O, O, Z, O, O, O, Z);
    drive(O, O, I, 16'hFFFE, O, O, O, Z);
    chk1("wrap_redir_en", mem_en, 1'b0);
    drive(O, O, O, Z, O, O, O, Z);
    chk1("wrap_req_en", mem_en, 1'b1);
    chk16("wrap_req_addr", mem_addr, 16'hFFFE);
    drive(O, O, O, Z, O, I, O, 16'h7777);
    sbq.push_back('{16'h7777, 16'hFFFE});
    chk1("wrap_wait_en", mem_en, 1'b0);
    drive(O, O, O, Z, O, O, O, Z);
    chk1("wrap_valid", valid, 1'b1);
    chk16("wrap_pc2", pc2, 16'h0000);
    chk1("wrap_err", err, 1'b0);
    drive(O, O, O, Z, O, O, O, Z);
    chk1("wrap_next_en", mem_en, 1'b1);
    chk16("wrap_next_addr", mem_addr, 16'h0000);

    drive(O, O, O, Z, O, O, O, Z);
    chk16("sb_drain", 16'(sbq.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
